// File: rtl/decode_collate_ctrl.sv
// decode_collate_ctrl
//   Sequencer between the fetch buffer and the combinational decode core.
//   Accepts one 32-bit instruction dword per handshake. It collects a second
//   dword when the decode core asks for collation or when a 32-bit literal
//   constant source is present. The assembled instruction is then held until
//   the issue stage accepts it.
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   fetch_valid/ready       dword handshake from fetch
//   fetch_wfid/pc/instr     wavefront id, byte address and dword from fetch
//   flush, flush_wfid       discard in-flight work of one wavefront
//   dec_instr               {hi, lo} to decode core collated_instr
//   dec_collate_done        to decode core collate_done
//   dec_collate_required    from decode core: instruction needs a second dword
//   dec_fu, dec_s1_field,
//   dec_s2_field            from decode core: used for literal detection
//   out_valid/ready         decoded instruction handshake to issue
//   out_wfid/pc/size        wavefront id, pc of first dword, 0=4B / 1=8B
//   collate_err             pulse: second dword came from another wavefront
module decode_collate_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [5:0]  fetch_wfid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr,
  input  logic        flush,
  input  logic [5:0]  flush_wfid,
  output logic [63:0] dec_instr,
  output logic        dec_collate_done,
  input  logic        dec_collate_required,
  input  logic [1:0]  dec_fu,
  input  logic [9:0]  dec_s1_field,
  input  logic [9:0]  dec_s2_field,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_wfid,
  output logic [31:0] out_pc,
  output logic        out_size,
  output logic        collate_err
);

  typedef enum logic [1:0] {IDLE, EVAL, WAIT2, HOLD} state_t;

  // Decode-core encoding of the literal-constant source operand.
  localparam logic [9:0] LITERAL_SRC = 10'h2FF;

  state_t      state, state_nxt;
  logic [31:0] lo, lo_nxt;
  logic [31:0] hi, hi_nxt;
  logic [31:0] pc, pc_nxt;
  logic [5:0]  wfid, wfid_nxt;
  logic        size, size_nxt;

  logic flush_hit;
  logic need2;
  logic wfid_match;

  assign flush_hit  = flush && (flush_wfid == wfid) && (state != IDLE);
  assign need2      = dec_collate_required ||
                      ((dec_fu != 2'd0) &&
                       ((dec_s1_field == LITERAL_SRC) || (dec_s2_field == LITERAL_SRC)));
  assign wfid_match = (fetch_wfid == wfid);

  assign fetch_ready      = (state == IDLE) || (state == WAIT2);
  assign out_valid        = (state == HOLD) && !flush_hit;
  assign dec_instr        = {hi, lo};
  assign dec_collate_done = (state == HOLD) && size;
  assign out_wfid         = wfid;
  assign out_pc           = pc;
  assign out_size         = size;

  always_comb begin
    state_nxt   = state;
    lo_nxt      = lo;
    hi_nxt      = hi;
    pc_nxt      = pc;
    wfid_nxt    = wfid;
    size_nxt    = size;
    collate_err = 1'b0;
    case (state)
      IDLE: begin
        // A dword whose own wavefront is being flushed is accepted and dropped.
        if (fetch_valid && !(flush && (flush_wfid == fetch_wfid))) begin
          lo_nxt    = fetch_instr;
          hi_nxt    = '0;
          wfid_nxt  = fetch_wfid;
          pc_nxt    = fetch_pc;
          size_nxt  = 1'b0;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        if (flush_hit)  state_nxt = IDLE;
        else if (need2) state_nxt = WAIT2;
        else begin
          size_nxt  = 1'b0;
          state_nxt = HOLD;
        end
      end
      WAIT2: begin
        // The mismatch is reported on any mismatched accept, flush or not.
        collate_err = fetch_valid && !wfid_match;
        if (flush_hit) state_nxt = IDLE;
        else if (fetch_valid) begin
          if (wfid_match) begin
            hi_nxt    = fetch_instr;
            size_nxt  = 1'b1;
            state_nxt = HOLD;
          end else begin
            lo_nxt    = fetch_instr;
            hi_nxt    = '0;
            wfid_nxt  = fetch_wfid;
            pc_nxt    = fetch_pc;
            state_nxt = EVAL;
          end
        end
      end
      HOLD: begin
        if (flush_hit || out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lo    <= '0;
      hi    <= '0;
      pc    <= '0;
      wfid  <= '0;
      size  <= 1'b0;
    end else begin
      state <= state_nxt;
      lo    <= lo_nxt;
      hi    <= hi_nxt;
      pc    <= pc_nxt;
      wfid  <= wfid_nxt;
      size  <= size_nxt;
    end
  end

endmodule

// File: tb/tb_decode_collate_ctrl.sv
// Testbench for decode_collate_ctrl: directed scenarios followed by a
// randomized run, checked against a transaction-level reference model.
module tb_decode_collate_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [5:0]  fetch_wfid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        flush;
  logic [5:0]  flush_wfid;
  logic [63:0] dec_instr;
  logic        dec_collate_done;
  logic        dec_collate_required;
  logic [1:0]  dec_fu;
  logic [9:0]  dec_s1_field;
  logic [9:0]  dec_s2_field;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_wfid;
  logic [31:0] out_pc;
  logic        out_size;
  logic        collate_err;

  decode_collate_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_wfid(fetch_wfid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .flush(flush), .flush_wfid(flush_wfid),
    .dec_instr(dec_instr), .dec_collate_done(dec_collate_done),
    .dec_collate_required(dec_collate_required), .dec_fu(dec_fu),
    .dec_s1_field(dec_s1_field), .dec_s2_field(dec_s2_field),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wfid(out_wfid), .out_pc(out_pc), .out_size(out_size),
    .collate_err(collate_err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned issued = 0;

  // Reference model: the instruction in flight as a list of collected dwords.
  bit          have;     // an instruction is in flight
  bit          judged;   // the decode core has been consulted for it
  bit          need2;    // verdict: a second dword is required
  logic [31:0] words[$];
  logic [5:0]  m_wfid;
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit waiting();
    return have && judged && need2 && (words.size() == 1);
  endfunction

  function automatic bit holding();
    return have && judged && (!need2 || (words.size() == 2));
  endfunction

  function automatic bit flush_match();
    return have && flush && (flush_wfid == m_wfid);
  endfunction

  task automatic model_reset();
    have = 0; judged = 0; need2 = 0;
    words.delete();
  endtask

  task automatic model_compare();
    logic [31:0] hi_exp;
    chk("fetch_ready", 64'(fetch_ready), 64'(!have || waiting()));
    chk("out_valid", 64'(out_valid), 64'(holding() && !flush_match()));
    chk("collate_err", 64'(collate_err),
        64'(waiting() && fetch_valid && (fetch_wfid != m_wfid)));
    chk("collate_done", 64'(dec_collate_done), 64'(holding() && (words.size() == 2)));
    if (have) begin
      hi_exp = (words.size() == 2) ? words[1] : 32'h0;
      chk("dec_instr", dec_instr, {hi_exp, words[0]});
    end
    if (holding()) begin
      chk("out_wfid", 64'(out_wfid), 64'(m_wfid));
      chk("out_pc", 64'(out_pc), 64'(m_pc));
      chk("out_size", 64'(out_size), 64'(words.size() == 2));
    end
  endtask

  task automatic start_new();
    words.delete();
    words.push_back(fetch_instr);
    m_wfid = fetch_wfid;
    m_pc   = fetch_pc;
    judged = 0;
  endtask

  task automatic model_advance();
    if (!have) begin
      if (fetch_valid && !(flush && (flush_wfid == fetch_wfid))) begin
        have = 1;
        start_new();
      end
    end else if (flush_match()) begin
      have = 0;
    end else if (!judged) begin
      judged = 1;
      need2  = dec_collate_required ||
               ((dec_fu != 0) && ((dec_s1_field == 10'h2FF) || (dec_s2_field == 10'h2FF)));
    end else if (waiting()) begin
      if (fetch_valid) begin
        if (fetch_wfid == m_wfid) words.push_back(fetch_instr);
        else start_new();
      end
    end else if (out_ready) begin
      have = 0;
      issued++;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    model_compare();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_valid = 0; fetch_wfid = '0; fetch_pc = '0; fetch_instr = '0;
    flush = 0; flush_wfid = '0;
    dec_collate_required = 0; dec_fu = '0; dec_s1_field = '0; dec_s2_field = '0;
    out_ready = 0;
  endtask

  task automatic send(input logic [5:0] w, input logic [31:0] p, input logic [31:0] d);
    fetch_valid = 1; fetch_wfid = w; fetch_pc = p; fetch_instr = d;
  endtask

  function automatic logic [9:0] rand_src();
    if ($urandom_range(0, 4) == 0) return 10'h2FF;
    return 10'($urandom_range(0, 254));
  endfunction

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_collate_err", 64'(collate_err), 64'd0);
    chk("rst_dec_instr", dec_instr, 64'd0);
    chk("rst_collate_done", 64'(dec_collate_done), 64'd0);
    chk("rst_out_size", 64'(out_size), 64'd0);
    @(negedge clk);
    rst_n = 1;

    // SOP2 single dword
    out_ready = 1;
    send(6'd3, 32'h100, 32'h8000_0201);
    cycle();
    fetch_valid = 0;
    cycle();
    #1;
    chk("sop2_valid_n2", 64'(out_valid), 64'd1);
    chk("sop2_pc", 64'(out_pc), 64'h100);
    chk("sop2_size", 64'(out_size), 64'd0);
    chk("sop2_done", 64'(dec_collate_done), 64'd0);
    cycle();
    #1 chk("sop2_one_hold", 64'(out_valid), 64'd0);
    cycle();

    // VOP3a two dwords
    dec_collate_required = 1;
    send(6'd5, 32'h200, 32'hD210_0001);
    cycle();
    fetch_valid = 0;
    cycle();
    #1 chk("vop3_wait2_ready", 64'(fetch_ready), 64'd1);
    send(6'd5, 32'h204, 32'h0000_0402);
    cycle();
    fetch_valid = 0;
    dec_collate_required = 0;
    #1;
    chk("vop3_valid", 64'(out_valid), 64'd1);
    chk("vop3_instr", dec_instr, 64'h0000_0402_D210_0001);
    chk("vop3_done", 64'(dec_collate_done), 64'd1);
    chk("vop3_size", 64'(out_size), 64'd1);
    cycle();

    // VOP2 with literal constant
    dec_fu = 2'd1; dec_s1_field = 10'h2FF;
    send(6'd4, 32'h300, 32'h0200_00FF);
    cycle();
    fetch_valid = 0;
    cycle();
    send(6'd4, 32'h304, 32'h3F80_0000);
    cycle();
    fetch_valid = 0; dec_fu = '0; dec_s1_field = '0;
    #1;
    chk("lit_size", 64'(out_size), 64'd1);
    chk("lit_hi", 64'(dec_instr[63:32]), 64'h3F80_0000);
    cycle();

    // Second dword from another wavefront
    dec_collate_required = 1;
    send(6'd1, 32'h400, 32'hD000_1111);
    cycle();
    fetch_valid = 0;
    cycle();
    send(6'd2, 32'h500, 32'h8000_2222);
    dec_collate_required = 0;
    #1 chk("cerr_pulse", 64'(collate_err), 64'd1);
    cycle();
    fetch_valid = 0;
    #1 chk("cerr_once", 64'(collate_err), 64'd0);
    cycle();
    #1;
    chk("cerr_valid", 64'(out_valid), 64'd1);
    chk("cerr_wfid", 64'(out_wfid), 64'd2);
    chk("cerr_pc", 64'(out_pc), 64'h500);
    cycle();

    // Stall in HOLD, non-matching flush, then matching flush
    out_ready = 0;
    send(6'd9, 32'h600, 32'h8000_3333);
    cycle();
    fetch_valid = 0;
    cycle();
    repeat (5) cycle();
    flush = 1; flush_wfid = 6'd10;
    #1 chk("flush_other_valid", 64'(out_valid), 64'd1);
    cycle();
    flush_wfid = 6'd9;
    #1 chk("flush_hit_valid", 64'(out_valid), 64'd0);
    cycle();
    flush = 0;
    #1;
    chk("flush_idle_ready", 64'(fetch_ready), 64'd1);
    chk("flush_idle_valid", 64'(out_valid), 64'd0);

    // Dword of a wavefront being flushed while idle is dropped
    send(6'd12, 32'h700, 32'h8000_4444);
    flush = 1; flush_wfid = 6'd12;
    cycle();
    fetch_valid = 0; flush = 0;
    #1 chk("drop_ready", 64'(fetch_ready), 64'd1);
    cycle();
    #1 chk("drop_no_valid", 64'(out_valid), 64'd0);

    // Reset while waiting for a second dword
    dec_collate_required = 1;
    send(6'd7, 32'h800, 32'hD000_5555);
    cycle();
    fetch_valid = 0;
    cycle();
    dec_collate_required = 0;
    rst_n = 0;
    #1;
    chk("mrst_instr", dec_instr, 64'd0);
    chk("mrst_ready", 64'(fetch_ready), 64'd1);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    send(6'd7, 32'h900, 32'h8000_6666);
    cycle();
    fetch_valid = 0;
    cycle();
    #1;
    chk("mrst_first_size", 64'(out_size), 64'd0);
    chk("mrst_first_pc", 64'(out_pc), 64'h900);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      fetch_valid          = ($urandom_range(0, 9) < 6);
      fetch_wfid           = (have && ($urandom_range(0, 4) != 0)) ? m_wfid : 6'($urandom_range(0, 3));
      fetch_pc             = $urandom & 32'hFFFF_FFFC;
      fetch_instr          = $urandom;
      flush                = ($urandom_range(0, 19) == 0);
      flush_wfid           = $urandom_range(0, 1) ? m_wfid : 6'($urandom_range(0, 3));
      dec_collate_required = ($urandom_range(0, 3) == 0);
      dec_fu               = 2'($urandom_range(0, 3));
      dec_s1_field         = rand_src();
      dec_s2_field         = rand_src();
      out_ready            = ($urandom_range(0, 9) < 6);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
